// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_adder_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Host-side start/busy/done handshake and operand/result bus of the serial adder.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Existing 1-bit full-adder cell, purely combinational.
module CONG_TOAN_PHAN (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    assign S    = A ^ B ^ CIN;
    assign COUT = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell iterated LSB-first over WIDTH cycles,
// with start/busy/done handshake and back-to-back acceptance from DONE.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_co;
    logic             w_load;
    logic             w_last;

    CONG_TOAN_PHAN u_fa (
        .A    (r_sh_a[0]),
        .B    (r_sh_b[0]),
        .CIN  (r_carry),
        .S    (w_s),
        .COUT (w_co)
    );

    // A new operation may start from IDLE or directly from DONE.
    assign w_load = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_sh_a  <= bus.a;
                r_sh_b  <= bus.b;
                r_carry <= bus.cin;
                r_cnt   <= '0;
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                        r_carry <= w_co;
                        r_sh_a  <= r_sh_a >> 1;
                        r_sh_b  <= r_sh_b >> 1;
                        // On the MSB step r_carry is the carry into the MSB.
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_cout  <= w_co;
                            r_ovf   <= r_carry ^ w_co;
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= CNT_W'(r_cnt + 1'b1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;

endmodule
